// File: rtl/spi_serf_pkg.sv
// Shared frame geometry and FSM state type for the iNEMO-style SPI serf.
package spi_serf_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned RW_BIT     = 15;
   localparam logic [7:0]  IDLE_TX    = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      DONE
   } state_t;

endpackage

// File: rtl/spi_serf_sync.sv
// N-stage synchronizer for one async input, with rise/fall pulses on the synchronized level.
module spi_serf_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   // Deliberately not reset: a mid-frame rst must not fake an SS_n edge.
   logic [STAGES-1:0] chain;
   logic              q_d;

   always_ff @(posedge clk) begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/spi_serf_inemo.sv
// SPI serf for 16-bit iNEMO frames (R/W + 7-bit address, 8-bit data) onto a register-file handshake.
// Define SPI_SERF_FRM_ERR_EN to add the frm_err output and the SCLK overcount check.
module spi_serf_inemo
   import spi_serf_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned RD_LAT      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_vld,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy
`ifdef SPI_SERF_FRM_ERR_EN
   ,
   output logic              frm_err
`endif
);

   logic ss_lvl, ss_rise, ss_fall;
   logic sck_lvl, sck_rise_raw, sck_fall_raw;
   logic mosi_s, mosi_rise, mosi_fall;
   logic sck_rise, sck_fall;
   logic unused_sync;

   spi_serf_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
      .clk(clk), .d(SS_n), .q(ss_lvl), .rise(ss_rise), .fall(ss_fall));
   spi_serf_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .d(SCLK), .q(sck_lvl), .rise(sck_rise_raw), .fall(sck_fall_raw));
   spi_serf_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .d(MOSI), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

   assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};
   assign sck_rise    = sck_rise_raw & ~ss_lvl;
   assign sck_fall    = sck_fall_raw & ~ss_lvl;

   state_t            state;
   logic [4:0]        bit_cnt;
   logic [DATA_W-1:0] rx, tx, rx_nxt;
   logic              rw;
   logic [2:0]        rd_lat;
`ifdef SPI_SERF_FRM_ERR_EN
   logic              over;
`endif

   assign rx_nxt = {rx[DATA_W-2:0], mosi_s};
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         rx      <= '0;
         tx      <= '0;
         rw      <= 1'b0;
         rd_lat  <= '0;
         MISO    <= 1'b1;
         rd_req  <= 1'b0;
         wr_vld  <= 1'b0;
         rd_addr <= '0;
         wr_addr <= '0;
         wr_data <= '0;
`ifdef SPI_SERF_FRM_ERR_EN
         over    <= 1'b0;
         frm_err <= 1'b0;
`endif
      end else begin
         rd_req <= 1'b0;
         wr_vld <= 1'b0;
`ifdef SPI_SERF_FRM_ERR_EN
         frm_err <= 1'b0;
`endif
         // Read latency runs independently of the FSM so an aborted read still completes harmlessly.
         if (rd_req)
            rd_lat <= 3'(RD_LAT);
         else if (rd_lat != '0)
            rd_lat <= rd_lat - 1'b1;
         if (rd_lat == 3'd1)
            tx <= rd_data;

         case (state)
            IDLE: begin
               MISO <= 1'b1;
               if (ss_fall) begin
                  state   <= ADDR;
                  bit_cnt <= '0;
                  rx      <= '0;
                  tx      <= IDLE_TX;
`ifdef SPI_SERF_FRM_ERR_EN
                  over    <= 1'b0;
`endif
               end
            end
            ADDR, DATA: begin
               if (ss_rise) begin
                  state <= IDLE;
                  MISO  <= 1'b1;
`ifdef SPI_SERF_FRM_ERR_EN
                  frm_err <= 1'b1;
`endif
               end else begin
                  if (sck_rise) begin
                     rx      <= rx_nxt;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (state == ADDR && bit_cnt == 5'(FRAME_BITS/2 - 1)) begin
                        state   <= DATA;
                        rw      <= rx_nxt[RW_BIT-DATA_W];
                        rd_addr <= rx_nxt[ADDR_W-1:0];
                        wr_addr <= rx_nxt[ADDR_W-1:0];
                        rd_req  <= rx_nxt[RW_BIT-DATA_W];
                        if (!rx_nxt[RW_BIT-DATA_W])
                           tx <= IDLE_TX;
                     end else if (state == DATA && bit_cnt == 5'(FRAME_BITS - 1)) begin
                        state <= DONE;
                     end
                  end
                  if (sck_fall) begin
                     MISO <= tx[DATA_W-1];
                     tx   <= {tx[DATA_W-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
`ifdef SPI_SERF_FRM_ERR_EN
               if (sck_rise)
                  over <= 1'b1;
`endif
               if (ss_rise) begin
                  state <= IDLE;
                  MISO  <= 1'b1;
`ifdef SPI_SERF_FRM_ERR_EN
                  frm_err <= over;
                  if (!rw && !over) begin
`else
                  if (!rw) begin
`endif
                     wr_vld  <= 1'b1;
                     wr_data <= rx;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_serf_inemo.sv
// Directed bench for spi_serf_inemo: monarch-side frames, register-file read responder, pulse monitors.
module tb_spi_serf_inemo;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned RD_LAT      = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       SS_n = 1'b1;
   logic       SCLK = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic       rd_req;
   logic [6:0] rd_addr;
   logic [7:0] rd_data = 8'hFF;
   logic       wr_vld;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
`ifdef SPI_SERF_FRM_ERR_EN
   logic       frm_err;
`endif

   spi_serf_inemo #(.SYNC_STAGES(SYNC_STAGES), .RD_LAT(RD_LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_vld  (wr_vld),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
`ifdef SPI_SERF_FRM_ERR_EN
      ,
      .frm_err (frm_err)
`endif
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_rd = 0;
   int         n_wr = 0;
   int         n_fe = 0;
   logic [6:0] last_rd_addr = '0;
   logic [6:0] last_wr_addr = '0;
   logic [7:0] last_wr_data = '0;
   logic [7:0] rd_resp = 8'h00;
   logic [4:0] pipe = '0;

   // Register file stand-in: data valid only in the cycle ending at the sampling edge.
   always @(negedge clk) begin
      if (rd_req) begin
         n_rd++;
         last_rd_addr = rd_addr;
      end
      if (wr_vld) begin
         n_wr++;
         last_wr_addr = wr_addr;
         last_wr_data = wr_data;
      end
`ifdef SPI_SERF_FRM_ERR_EN
      if (frm_err) n_fe++;
`endif
      pipe    = {pipe[3:0], rd_req};
      rd_data = pipe[RD_LAT] ? rd_resp : 8'hFF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},    32'(busy),    32'h0);
      check({tag, "_miso"},    32'(MISO),    32'h1);
      check({tag, "_rd_req"},  32'(rd_req),  32'h0);
      check({tag, "_wr_vld"},  32'(wr_vld),  32'h0);
      check({tag, "_rd_addr"}, 32'(rd_addr), 32'h0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
      check({tag, "_wr_data"}, 32'(wr_data), 32'h0);
   endtask

   // Monarch side: SCLK idles high, MOSI changes on fall, MISO captured on rise, clk/32 SCLK.
   task automatic frame(input logic [15:0] mo, input int nbits, input int rst_at,
                        input int idle_after, output logic [15:0] mi);
      mi   = '0;
      SS_n = 1'b0;
      wait_clks(16);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = mo[15-i];
         if (i == rst_at) begin
            wait_clks(8);
            rst = 1'b1;
            wait_clks(1);
            rst = 1'b0;
            check_reset_vals("midrst");
            wait_clks(7);
         end else begin
            wait_clks(16);
         end
         SCLK = 1'b1;
         mi[15-i] = MISO;
         wait_clks(16);
      end
      SS_n = 1'b1;
      wait_clks(idle_after);
   endtask

   initial begin
      logic [15:0] m1, m2;
      int wr0, rd0, fe0;

      wait_clks(8);
      check_reset_vals("reset");
      rst = 1'b0;
      wait_clks(5);

      wr0 = n_wr; rd0 = n_rd;
      frame(16'h0D02, 16, -1, 20, m1);
      check("wr_count",   32'(n_wr - wr0), 32'd1);
      check("wr_addr",    32'(last_wr_addr), 32'h0D);
      check("wr_data",    32'(last_wr_data), 32'h02);
      check("wr_no_rd",   32'(n_rd - rd0), 32'd0);
      check("wr_miso",    32'(m1), 32'h0000);
      check("wr_busy",    32'(busy), 32'h0);
      check("idle_miso",  32'(MISO), 32'h1);

      wr0 = n_wr; rd0 = n_rd;
      rd_resp = 8'h6A;
      frame(16'h8F00, 16, -1, 20, m1);
      check("rd_count",   32'(n_rd - rd0), 32'd1);
      check("rd_addr",    32'(last_rd_addr), 32'h0F);
      check("rd_miso",    32'(m1), 32'h006A);
      check("rd_no_wr",   32'(n_wr - wr0), 32'd0);

      wr0 = n_wr; rd0 = n_rd;
      rd_resp = 8'h55;
      frame(16'h0D02, 16, -1, 2, m1);
      frame(16'hA200, 16, -1, 20, m2);
      check("b2b_wr_count", 32'(n_wr - wr0), 32'd1);
      check("b2b_rd_count", 32'(n_rd - rd0), 32'd1);
      check("b2b_wr_addr",  32'(last_wr_addr), 32'h0D);
      check("b2b_wr_data",  32'(last_wr_data), 32'h02);
      check("b2b_rd_addr",  32'(last_rd_addr), 32'h22);
      check("b2b_miso1",    32'(m1), 32'h0000);
      check("b2b_miso2",    32'(m2), 32'h0055);

      wr0 = n_wr; rd0 = n_rd; fe0 = n_fe;
      frame(16'h1234, 11, -1, 20, m1);
      check("abort_no_wr", 32'(n_wr - wr0), 32'd0);
      check("abort_no_rd", 32'(n_rd - rd0), 32'd0);
      check("abort_busy",  32'(busy), 32'h0);
`ifdef SPI_SERF_FRM_ERR_EN
      check("abort_frm_err", 32'(n_fe - fe0), 32'd1);
`endif
      wr0 = n_wr;
      frame(16'h0D02, 16, -1, 20, m1);
      check("post_abort_wr",   32'(n_wr - wr0), 32'd1);
      check("post_abort_addr", 32'(last_wr_addr), 32'h0D);
      check("post_abort_data", 32'(last_wr_data), 32'h02);

      wr0 = n_wr; rd0 = n_rd; fe0 = n_fe;
      frame(16'h0D02, 16, 4, 20, m1);
      check("rst_no_wr",   32'(n_wr - wr0), 32'd0);
      check("rst_no_rd",   32'(n_rd - rd0), 32'd0);
      check("rst_busy",    32'(busy), 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
`ifdef SPI_SERF_FRM_ERR_EN
      check("rst_frm_err", 32'(n_fe - fe0), 32'd0);
`endif
      wr0 = n_wr;
      frame(16'h0D02, 16, -1, 20, m1);
      check("post_rst_wr",   32'(n_wr - wr0), 32'd1);
      check("post_rst_addr", 32'(wr_addr), 32'h0D);
      check("post_rst_data", 32'(wr_data), 32'h02);
      check("post_rst_miso", 32'(m1), 32'h0000);

      wr0 = n_wr; rd0 = n_rd;
      for (int i = 0; i < 10; i++) begin
         SCLK = ~SCLK;
         MOSI = ~MOSI;
         wait_clks(16);
         check("ss_high_busy", 32'(busy), 32'h0);
         check("ss_high_miso", 32'(MISO), 32'h1);
      end
      check("ss_high_no_rd", 32'(n_rd - rd0), 32'd0);
      check("ss_high_no_wr", 32'(n_wr - wr0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
